nibble_serial_addsub_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

---
 rtl/nibble_serial_addsub_ctrl_if.sv | 24 ++
 rtl/nibble_serial_addsub_ctrl.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Operand/result bundle between requester (master) and the nibble-serial add/sub engine (slave).
interface nibble_serial_addsub_ctrl_if;
  localparam int unsigned DW = 16;

  logic          start;
  logic          op;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          cout;
  logic          ovf;

  modport master (
    output start, op, A, B,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// 16-bit add/subtract computed one nibble per cycle through a single 4-bit adder slice.
// Optional signed overflow detection is built only when ADDSUB_OVF_EN is defined.
module nibble_serial_addsub_ctrl (
  input logic                         clk,
  input logic                         rst_n,
  nibble_serial_addsub_ctrl_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] result_q, result_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef ADDSUB_OVF_EN
  logic          ovf_q, ovf_d;
  logic          carry_into_msb;
`endif

  // The one shared 4-bit full-adder slice; B is inverted for subtract, carry seeds with op.
  logic [SW-1:0] slice_a, slice_b, slice_sum;
  logic          slice_carry;
  logic [SW:0]   slice_full;

  assign slice_a     = SW'(a_q >> {cnt_q, 2'b00});
  assign slice_b     = SW'(b_q >> {cnt_q, 2'b00}) ^ {SW{op_q}};
  assign slice_full  = (SW+1)'(slice_a) + (SW+1)'(slice_b) + (SW+1)'(carry_q);
  assign slice_sum   = slice_full[SW-1:0];
  assign slice_carry = slice_full[SW];

`ifdef ADDSUB_OVF_EN
  assign carry_into_msb = slice_a[SW-1] ^ slice_b[SW-1] ^ slice_sum[SW-1];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.op;
          carry_d = bus.op;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        case (cnt_q)
          2'd0: result_d[3:0]   = slice_sum;
          2'd1: result_d[7:4]   = slice_sum;
          2'd2: result_d[11:8]  = slice_sum;
          2'd3: result_d[15:12] = slice_sum;
          default: result_d = result_q;
        endcase
        carry_d = slice_carry;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cout_d  = slice_carry;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef ADDSUB_OVF_EN
          ovf_d   = carry_into_msb ^ slice_carry;
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef ADDSUB_OVF_EN
  assign bus.ovf    = ovf_q;
`else
  assign bus.ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench for nibble_serial_addsub_ctrl: directed cases plus randomized traffic
// compared every cycle against an arithmetic/timing reference model.
module tb_nibble_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl_if bif ();

  nibble_serial_addsub_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_known = 1'b0;
  bit          m_active = 1'b0;
  int          m_k = 0;
  bit          m_busy, m_done;
  bit          m_valid = 1'b0;
  logic [15:0] m_a, m_b, m_result;
  logic        m_op, m_cout, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected results computed from plain arithmetic on the latched operands.
  task automatic model_compute();
    logic [16:0] full;
    if (!m_op) begin
      full     = {1'b0, m_a} + {1'b0, m_b};
      m_result = full[15:0];
      m_cout   = full[16];
    end else begin
      m_result = m_a - m_b;
      m_cout   = (m_a >= m_b);
    end
`ifdef ADDSUB_OVF_EN
    if (!m_op) m_ovf = (m_a[15] == m_b[15]) && (m_result[15] != m_a[15]);
    else       m_ovf = (m_a[15] != m_b[15]) && (m_result[15] != m_a[15]);
`else
    m_ovf = 1'b0;
`endif
  endtask

  // Busy for five cycles after an accepted start, done on the fourth edge after it.
  task automatic model_edge();
    if (!rst_n) begin
      m_known = 1'b1; m_active = 1'b0; m_k = 0;
      m_busy = 1'b0; m_done = 1'b0;
      m_result = 16'h0000; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b1;
    end else if (m_known) begin
      if (!m_active) begin
        if (bif.start) begin
          m_active = 1'b1; m_k = 0; m_busy = 1'b1; m_done = 1'b0;
          m_a = bif.A; m_b = bif.B; m_op = bif.op; m_valid = 1'b0;
        end
      end else begin
        m_k++;
        if (m_k == 4) begin
          m_done = 1'b1; model_compute(); m_valid = 1'b1;
        end else if (m_k == 5) begin
          m_done = 1'b0; m_busy = 1'b0; m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic compare();
    if (!m_known) return;
    check("busy", 32'(bif.busy), 32'(m_busy));
    check("done", 32'(bif.done), 32'(m_done));
    if (m_done || (!m_busy && m_valid)) begin
      check("result", 32'(bif.result), 32'(m_result));
      check("cout", 32'(bif.cout), 32'(m_cout));
      check("ovf", 32'(bif.ovf), 32'(m_ovf));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Directed operation with literal expectations; operands are scrambled after the start edge.
  task automatic run_op(input string name, input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic ec, input logic eo);
    int lat;
    bit seen;
    bif.start = 1'b1; bif.op = o; bif.A = a; bif.B = b;
    cycle();
    bif.start = 1'b0; bif.op = 1'($urandom); bif.A = 16'($urandom); bif.B = 16'($urandom);
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle(); lat++;
      if (bif.done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_done_timeout actual=none expected=done within 8 cycles", name);
    end else begin
      check({name, "_latency"}, 32'(lat), 32'd4);
      check({name, "_result"}, 32'(bif.result), 32'(er));
      check({name, "_cout"}, 32'(bif.cout), 32'(ec));
      check({name, "_ovf"}, 32'(bif.ovf), 32'(eo));
    end
    cycle();
  endtask

  logic ovf_expect_40;
  int   done_cnt;
  logic [15:0] pick [4];

  initial begin
`ifdef ADDSUB_OVF_EN
    ovf_expect_40 = 1'b1;
`else
    ovf_expect_40 = 1'b0;
`endif
    rst_n = 1'b0; bif.start = 1'b0; bif.op = 1'b0; bif.A = '0; bif.B = '0;
    cycle(); cycle();
    check("reset_result", 32'(bif.result), 32'h0);
    check("reset_busy", 32'(bif.busy), 32'h0);
    rst_n = 1'b1;
    cycle();

    run_op("add",    1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
    run_op("wrap",   1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("sub_bw", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ok", 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    run_op("ovf",    1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, ovf_expect_40);
    cycle();
    check("idle_hold_result", 32'(bif.result), 32'h8000);

    // start held high through RUN/DONE with A changing: exactly one done
    done_cnt = 0;
    bif.start = 1'b1; bif.op = 1'b0; bif.A = 16'h1111; bif.B = 16'h2222;
    cycle();
    for (int i = 0; i < 5; i++) begin
      bif.A = 16'($urandom);
      cycle();
      if (bif.done) begin
        done_cnt++;
        check("held_start_result", 32'(bif.result), 32'h3333);
      end
    end
    bif.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bif.done) done_cnt++;
    end
    check("held_start_done_count", 32'(done_cnt), 32'd1);

    // reset at edge N+2 aborts without done, then a fresh start completes
    done_cnt = 0;
    bif.start = 1'b1; bif.op = 1'b0; bif.A = 16'h0F0F; bif.B = 16'h0101;
    cycle();
    bif.start = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    check("abort_busy", 32'(bif.busy), 32'h0);
    check("abort_result", 32'(bif.result), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bif.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op("after_abort", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, ovf_expect_40);

    // randomized traffic with boundary-biased operands and occasional reset
    pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h7FFF; pick[3] = 16'h8000;
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      bif.start = ($urandom_range(0, 2) == 0);
      bif.op    = 1'($urandom);
      bif.A     = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      bif.B     = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      cycle();
    end
    rst_n = 1'b1; bif.start = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
